level_sequencer: RTL

LEVEL_SEQUENCER -- requirements
Module: level_sequencer

---
 rtl/level_sequencer.sv | 125 ++++++++++++
 1 files changed

// File: rtl/level_sequencer.sv
// Game-level sequencer: load a pattern, show it, take the player's answer, ask the judge, advance or end.
// Latency: every output is registered and follows the state entered on the same clock edge.
// Backpressure: none; a verdict is taken only in the cycle after levelComplete, and start is honoured only when no level is in progress.
module level_sequencer #(
    parameter int MAX_LEVEL  = 8,
    parameter int SHOW_TICKS = 4,
    parameter int PLAY_TICKS = 20
) (
    input  logic       Clk100M,
    input  logic       Reset,
    input  logic       start,
    input  logic       tick,
    input  logic       userDone,
    input  logic       incLevel,
    input  logic       lose,
    output logic       levelComplete,
    output logic       newLevel,
    output logic       showPhase,
    output logic       playPhase,
    output logic [3:0] level,
    output logic [4:0] timeLeft,
    output logic       gameOver,
    output logic       gameWon
);

    localparam logic [3:0] MAX_LVL    = 4'(MAX_LEVEL);
    localparam logic [4:0] SHOW_COUNT = 5'(SHOW_TICKS);
    localparam logic [4:0] PLAY_COUNT = 5'(PLAY_TICKS);

    typedef enum logic [2:0] {IDLE, LOAD, SHOW, PLAY, JUDGE, EVAL, OVER, WON} state_t;

    state_t     state, stateNext;
    logic [4:0] showCnt, showCntNext;
    logic [4:0] timeLeftNext;
    logic [3:0] levelNext;
    logic       timedOut, timedOutNext;

    always_comb begin
        stateNext    = state;
        levelNext    = level;
        timeLeftNext = timeLeft;
        showCntNext  = showCnt;
        timedOutNext = timedOut;
        case (state)
            IDLE, OVER, WON: begin
                if (start) begin
                    stateNext    = LOAD;
                    levelNext    = 4'd1;
                    timedOutNext = 1'b0;
                end
            end
            LOAD: begin
                showCntNext = SHOW_COUNT;
                stateNext   = SHOW;
            end
            SHOW: begin
                if (tick) begin
                    showCntNext = showCnt - 5'd1;
                    if (showCnt == 5'd1) begin
                        stateNext    = PLAY;
                        timeLeftNext = PLAY_COUNT;
                    end
                end
            end
            PLAY: begin
                // An answer arriving with the expiring tick still counts as on time.
                if (userDone) begin
                    stateNext = JUDGE;
                end else if (tick) begin
                    timeLeftNext = timeLeft - 5'd1;
                    if (timeLeft == 5'd1) begin
                        timedOutNext = 1'b1;
                        stateNext    = JUDGE;
                    end
                end
            end
            JUDGE: stateNext = EVAL;
            EVAL: begin
                if (timedOut || (lose && !incLevel)) begin
                    stateNext = OVER;
                end else if (incLevel) begin
                    if (level >= MAX_LVL) begin
                        stateNext = WON;
                    end else begin
                        levelNext    = level + 4'd1;
                        timedOutNext = 1'b0;
                        stateNext    = LOAD;
                    end
                end else begin
                    stateNext = OVER;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge Clk100M) begin
        if (Reset) begin
            state         <= IDLE;
            level         <= 4'd0;
            timeLeft      <= 5'd0;
            showCnt       <= 5'd0;
            timedOut      <= 1'b0;
            newLevel      <= 1'b0;
            showPhase     <= 1'b0;
            playPhase     <= 1'b0;
            levelComplete <= 1'b0;
            gameOver      <= 1'b0;
            gameWon       <= 1'b0;
        end else begin
            state         <= stateNext;
            level         <= levelNext;
            timeLeft      <= timeLeftNext;
            showCnt       <= showCntNext;
            timedOut      <= timedOutNext;
            newLevel      <= (stateNext == LOAD);
            showPhase     <= (stateNext == SHOW);
            playPhase     <= (stateNext == PLAY);
            levelComplete <= (stateNext == JUDGE);
            gameOver      <= (stateNext == OVER);
            gameWon       <= (stateNext == WON);
        end
    end

endmodule
